// File: rtl/blake2_msg_streamer_if.sv
// Bundles the command, input byte stream, core load/digest and output ports of blake2_msg_streamer.
// The master modport is the host/core side and the slave modport is the streamer.
interface blake2_msg_streamer_if #(
  parameter int unsigned NN_W  = 7,
  parameter int unsigned LEN_W = 32,
  parameter int unsigned BB    = 128
);
  localparam int unsigned CIDX_W = $clog2(BB);

  logic              cmd_v_i;
  logic              cmd_ready_o;
  logic [NN_W-1:0]   cmd_kk_i;
  logic [NN_W-1:0]   cmd_nn_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              in_v_i;
  logic              in_ready_o;
  logic [7:0]        in_data_i;
  logic [NN_W-1:0]   core_kk_o;
  logic [NN_W-1:0]   core_nn_o;
  logic [BB-1:0]     core_ll_o;
  logic              core_block_first_o;
  logic              core_block_last_o;
  logic              core_data_v_o;
  logic [CIDX_W-1:0] core_data_idx_o;
  logic [7:0]        core_data_o;
  logic              core_ready_v_i;
  logic              core_h_v_i;
  logic [7:0]        core_h_i;
  logic              out_v_o;
  logic [7:0]        out_data_o;
  logic              out_last_o;
  logic              busy_o;
  logic              err_o;

  modport master (
    output cmd_v_i, cmd_kk_i, cmd_nn_i, cmd_len_i, in_v_i, in_data_i,
           core_ready_v_i, core_h_v_i, core_h_i,
    input  cmd_ready_o, in_ready_o, core_kk_o, core_nn_o, core_ll_o,
           core_block_first_o, core_block_last_o, core_data_v_o, core_data_idx_o,
           core_data_o, out_v_o, out_data_o, out_last_o, busy_o, err_o
  );

  modport slave (
    input  cmd_v_i, cmd_kk_i, cmd_nn_i, cmd_len_i, in_v_i, in_data_i,
           core_ready_v_i, core_h_v_i, core_h_i,
    output cmd_ready_o, in_ready_o, core_kk_o, core_nn_o, core_ll_o,
           core_block_first_o, core_block_last_o, core_data_v_o, core_data_idx_o,
           core_data_o, out_v_o, out_data_o, out_last_o, busy_o, err_o
  );
endinterface

// File: rtl/blake2_msg_streamer.sv
// Feeds key/message bytes to a blake2 core as zero-padded, first/last-flagged blocks,
// then forwards the core's digest stream (minus its leading dummy byte) as a framed output.
module blake2_msg_streamer #(
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned W           = 64,
  parameter int unsigned BB          = 128,
  parameter int unsigned NN_W        = 7,
  parameter int unsigned LEN_W       = 32
) (
  input logic                  clk,
  input logic                  reset,
  blake2_msg_streamer_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(BLOCK_BYTES);
  localparam int unsigned CIDX_W = $clog2(BB);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_BWAIT, S_RESULT} state_e;

  state_e            state_q, state_d;
  logic [NN_W-1:0]   kk_q, kk_d, nn_q, nn_d, h_cnt_q, h_cnt_d;
  logic [BB-1:0]     ll_q, ll_d;
  logic [LEN_W-1:0]  msg_rem_q, msg_rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              first_q, first_d, last_q, last_d, key_blk_q, key_blk_d;
  logic              data_v_q, data_v_d;
  logic [CIDX_W-1:0] data_idx_q, data_idx_d;
  logic [7:0]        data_q, data_d, out_data_q, out_data_d;
  logic              out_v_q, out_v_d, out_last_q, out_last_d;
  logic              err_q, err_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;
  logic              byte_due_c;

  // A source byte is due while inside the key span of the key block or while message bytes remain.
  assign byte_due_c = key_blk_q ? (NN_W'(idx_q) < kk_q) : (msg_rem_q != '0);

  always_comb begin
    state_d    = state_q;
    kk_d       = kk_q;
    nn_d       = nn_q;
    ll_d       = ll_q;
    h_cnt_d    = h_cnt_q;
    msg_rem_d  = msg_rem_q;
    idx_d      = idx_q;
    first_d    = first_q;
    last_d     = last_q;
    key_blk_d  = key_blk_q;
    data_v_d   = 1'b0;
    data_idx_d = data_idx_q;
    data_d     = data_q;
    out_v_d    = 1'b0;
    out_data_d = out_data_q;
    out_last_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_v_i && cmd_ready_q) begin
          if (bus.cmd_nn_i == '0 || bus.cmd_nn_i > NN_W'(W) || bus.cmd_kk_i > NN_W'(W)) begin
            err_d = 1'b1;
          end else begin
            kk_d      = bus.cmd_kk_i;
            nn_d      = bus.cmd_nn_i;
            ll_d      = BB'(bus.cmd_len_i) + ((bus.cmd_kk_i != '0) ? BB'(BLOCK_BYTES) : BB'(0));
            msg_rem_d = bus.cmd_len_i;
            key_blk_d = (bus.cmd_kk_i != '0);
            first_d   = 1'b1;
            last_d    = 1'b0;
            state_d   = S_BWAIT;
          end
        end
      end
      S_BWAIT: begin
        if (bus.core_ready_v_i) begin
          idx_d   = '0;
          last_d  = key_blk_q ? (msg_rem_q == '0) : (msg_rem_q <= LEN_W'(BLOCK_BYTES));
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Pad bytes never stall; source bytes wait for in_v_i.
        if (!byte_due_c || bus.in_v_i) begin
          data_v_d   = 1'b1;
          data_idx_d = CIDX_W'(idx_q);
          data_d     = byte_due_c ? bus.in_data_i : 8'h00;
          if (byte_due_c && !key_blk_q && msg_rem_q != '0) msg_rem_d = msg_rem_q - LEN_W'(1);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(BLOCK_BYTES - 1)) begin
            key_blk_d = 1'b0;
            h_cnt_d   = '0;
            state_d   = last_q ? S_RESULT : S_GAP;
          end
        end
      end
      S_GAP: begin
        first_d = 1'b0;
        state_d = S_BWAIT;
      end
      S_RESULT: begin
        // The first digest beat is a dummy; the following nn beats are forwarded.
        if (bus.core_h_v_i) begin
          h_cnt_d = h_cnt_q + NN_W'(1);
          if (h_cnt_q != '0) begin
            out_v_d    = 1'b1;
            out_data_d = bus.core_h_i;
            if (h_cnt_q == nn_q) begin
              out_last_d = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE) || out_last_d;
    cmd_ready_d = (state_d == S_IDLE) && !out_last_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kk_q        <= '0;
      nn_q        <= '0;
      ll_q        <= '0;
      h_cnt_q     <= '0;
      msg_rem_q   <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      key_blk_q   <= 1'b0;
      data_v_q    <= 1'b0;
      data_idx_q  <= '0;
      data_q      <= '0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kk_q        <= kk_d;
      nn_q        <= nn_d;
      ll_q        <= ll_d;
      h_cnt_q     <= h_cnt_d;
      msg_rem_q   <= msg_rem_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      last_q      <= last_d;
      key_blk_q   <= key_blk_d;
      data_v_q    <= data_v_d;
      data_idx_q  <= data_idx_d;
      data_q      <= data_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready_o        = cmd_ready_q;
  assign bus.in_ready_o         = (state_q == S_LOAD) && byte_due_c;
  assign bus.core_kk_o          = kk_q;
  assign bus.core_nn_o          = nn_q;
  assign bus.core_ll_o          = ll_q;
  assign bus.core_block_first_o = first_q;
  assign bus.core_block_last_o  = last_q;
  assign bus.core_data_v_o      = data_v_q;
  assign bus.core_data_idx_o    = data_idx_q;
  assign bus.core_data_o        = data_q;
  assign bus.out_v_o            = out_v_q;
  assign bus.out_data_o         = out_data_q;
  assign bus.out_last_o         = out_last_q;
  assign bus.busy_o             = busy_q;
  assign bus.err_o              = err_q;
endmodule
